// File: rtl/sad_min_tracker.sv
// SAD minimum tracker: pipelined row-minimum comparator tree
// plus a running frame minimum that reports the best motion vector.
module sad_min_tracker #(
    parameter int N_CAND = 16,
    parameter int SAD_W  = 12,
    parameter int IDX_W  = 4,
    parameter int ROW_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [ROW_W-1:0]          in_row,
    input  logic [N_CAND*SAD_W-1:0]   in_sad,
    output logic                      row_valid,
    output logic [SAD_W-1:0]          row_sad,
    output logic [IDX_W-1:0]          row_x,
    output logic [ROW_W-1:0]          row_y,
    output logic                      best_valid,
    output logic [SAD_W-1:0]          best_sad,
    output logic [IDX_W-1:0]          best_x,
    output logic [ROW_W-1:0]          best_y
);

    localparam int LEVELS = $clog2(N_CAND);
    localparam int LR     = (LEVELS + 1) / 2;

    logic [LR-1:0]    v_q;
    logic [LR-1:0]    first_q;
    logic [LR-1:0]    last_q;
    logic [ROW_W-1:0] row_q [LR];

    logic [LR-1:0]    en;
    logic [LR-1:0]    f_in;
    logic [LR-1:0]    l_in;
    logic [ROW_W-1:0] r_in [LR];

    // Stage inputs: stage 0 takes the beat, later stages the previous stage
    always_comb begin
        en      = '0;
        f_in    = '0;
        l_in    = '0;
        en[0]   = in_valid;
        f_in[0] = in_first;
        l_in[0] = in_last;
        r_in[0] = in_row;
        for (int k = 1; k < LR; k++) begin
            en[k]   = v_q[k-1];
            f_in[k] = first_q[k-1];
            l_in[k] = last_q[k-1];
            r_in[k] = row_q[k-1];
        end
    end

    // Sideband delay line matched to the comparator tree stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int k = 0; k < LR; k++) row_q[k] <= '0;
        end else begin
            v_q <= en;
            for (int k = 0; k < LR; k++) begin
                if (en[k]) begin
                    first_q[k] <= f_in[k];
                    last_q[k]  <= l_in[k];
                    row_q[k]   <= r_in[k];
                end
            end
        end
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lv
        localparam int NN = N_CAND >> l;
        for (genvar i = 0; i < NN; i++) begin : g_n
            logic [SAD_W-1:0] s;
            logic [IDX_W-1:0] x;
            if (l == 0) begin : g_leaf
                assign s = in_sad[i*SAD_W +: SAD_W];
                assign x = IDX_W'(i);
            end else begin : g_node
                logic [SAD_W-1:0] s_d;
                logic [IDX_W-1:0] x_d;
                // Right operand wins only when strictly smaller
                always_comb begin
                    if (g_lv[l-1].g_n[2*i+1].s < g_lv[l-1].g_n[2*i].s) begin
                        s_d = g_lv[l-1].g_n[2*i+1].s;
                        x_d = g_lv[l-1].g_n[2*i+1].x;
                    end else begin
                        s_d = g_lv[l-1].g_n[2*i].s;
                        x_d = g_lv[l-1].g_n[2*i].x;
                    end
                end
                if ((l % 2 == 0) || (l == LEVELS)) begin : g_reg
                    // Stage register, loads only with a valid beat
                    always_ff @(posedge clk) begin
                        if (!rst_n) begin
                            s <= '1;
                            x <= '0;
                        end else if (en[(l+1)/2-1]) begin
                            s <= s_d;
                            x <= x_d;
                        end
                    end
                end else begin : g_wire
                    assign s = s_d;
                    assign x = x_d;
                end
            end
        end
    end

    assign row_valid = v_q[LR-1];
    assign row_sad   = g_lv[LEVELS].g_n[0].s;
    assign row_x     = g_lv[LEVELS].g_n[0].x;
    assign row_y     = row_q[LR-1];

    logic [SAD_W-1:0] run_sad_q, run_sad_d;
    logic [IDX_W-1:0] run_x_q, run_x_d;
    logic [ROW_W-1:0] run_y_q, run_y_d;
    logic             best_valid_q;
    logic [SAD_W-1:0] best_sad_q;
    logic [IDX_W-1:0] best_x_q;
    logic [ROW_W-1:0] best_y_q;

    // Next running minimum: first row reloads, others need strictly less
    always_comb begin
        run_sad_d = run_sad_q;
        run_x_d   = run_x_q;
        run_y_d   = run_y_q;
        if (row_valid && (first_q[LR-1] || (row_sad < run_sad_q))) begin
            run_sad_d = row_sad;
            run_x_d   = row_x;
            run_y_d   = row_y;
        end
    end

    // Running minimum and frame result, published on the last row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_sad_q    <= '1;
            run_x_q      <= '0;
            run_y_q      <= '0;
            best_valid_q <= 1'b0;
            best_sad_q   <= '1;
            best_x_q     <= '0;
            best_y_q     <= '0;
        end else begin
            run_sad_q    <= run_sad_d;
            run_x_q      <= run_x_d;
            run_y_q      <= run_y_d;
            best_valid_q <= row_valid & last_q[LR-1];
            if (row_valid && last_q[LR-1]) begin
                best_sad_q <= run_sad_d;
                best_x_q   <= run_x_d;
                best_y_q   <= run_y_d;
            end
        end
    end

    assign best_valid = best_valid_q;
    assign best_sad   = best_sad_q;
    assign best_x     = best_x_q;
    assign best_y     = best_y_q;

endmodule

// File: tb/tb_sad_min_tracker.sv
// Scoreboard bench for sad_min_tracker: default build plus a
// 64-candidate build for the wide-tree latency case.
module tb_sad_min_tracker;

    localparam int N  = 16;
    localparam int SW = 12;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             in_valid, in_first, in_last;
    logic [3:0]       in_row;
    logic [N*SW-1:0]  in_sad;
    logic             row_valid, best_valid;
    logic [SW-1:0]    row_sad, best_sad;
    logic [3:0]       row_x, row_y, best_x, best_y;

    logic             w_in_valid, w_in_first, w_in_last;
    logic [3:0]       w_in_row;
    logic [64*16-1:0] w_in_sad;
    logic             w_row_valid, w_best_valid;
    logic [15:0]      w_row_sad, w_best_sad;
    logic [5:0]       w_row_x, w_best_x;
    logic [3:0]       w_row_y, w_best_y;

    sad_min_tracker #(
        .N_CAND(16), .SAD_W(12), .IDX_W(4), .ROW_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .in_row(in_row), .in_sad(in_sad),
        .row_valid(row_valid), .row_sad(row_sad),
        .row_x(row_x), .row_y(row_y),
        .best_valid(best_valid), .best_sad(best_sad),
        .best_x(best_x), .best_y(best_y)
    );

    sad_min_tracker #(
        .N_CAND(64), .SAD_W(16), .IDX_W(6), .ROW_W(4)
    ) dutw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_first(w_in_first), .in_last(w_in_last),
        .in_row(w_in_row), .in_sad(w_in_sad),
        .row_valid(w_row_valid), .row_sad(w_row_sad),
        .row_x(w_row_x), .row_y(w_row_y),
        .best_valid(w_best_valid), .best_sad(w_best_sad),
        .best_x(w_best_x), .best_y(w_best_y)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sad;
        int x;
        int y;
        int due;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } dchk_t;

    exp_t  rq[$];
    exp_t  bq[$];
    dchk_t dq[$];
    int    errors = 0;
    int    checks = 0;
    bit    done = 1'b0;
    logic [N*SW-1:0] sv;

    task automatic fill(input int v);
        for (int k = 0; k < N; k++) sv[k*SW +: SW] = SW'(v);
    endtask

    task automatic setk(input int k, input int v);
        sv[k*SW +: SW] = SW'(v);
    endtask

    task automatic beat(input bit f, input bit l, input int row,
                        input int es, input int ex,
                        input int bs, input int bx, input int by);
        @(negedge clk);
        in_valid = 1'b1;
        in_first = f;
        in_last  = l;
        in_row   = 4'(row);
        in_sad   = sv;
        rq.push_back('{es, ex, row, cyc + 2});
        if (l) bq.push_back('{bs, bx, by, cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_first = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic dchk(input string nm, input int a, input int e);
        dq.push_back('{nm, a, e});
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (rq.size() > 0 || bq.size() > 0); t++)
            @(negedge clk);
    endtask

    exp_t  me;
    dchk_t md;

    always @(negedge clk) begin
        while (dq.size() > 0) begin
            md = dq.pop_front();
            checks++;
            if (md.act != md.exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d",
                         md.name, md.act, md.exp);
            end
        end
        if (row_valid) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL row_unexpected: got (%0d,%0d,%0d) at cyc %0d expected none",
                         row_sad, row_x, row_y, cyc);
            end else begin
                me = rq.pop_front();
                if (int'(row_sad) != me.sad || int'(row_x) != me.x ||
                    int'(row_y) != me.y || cyc != me.due) begin
                    errors++;
                    $display("FAIL row: got (%0d,%0d,%0d)@%0d expected (%0d,%0d,%0d)@%0d",
                             row_sad, row_x, row_y, cyc,
                             me.sad, me.x, me.y, me.due);
                end
            end
        end
        if (best_valid) begin
            checks++;
            if (bq.size() == 0) begin
                errors++;
                $display("FAIL best_unexpected: got (%0d,%0d,%0d) at cyc %0d expected none",
                         best_sad, best_x, best_y, cyc);
            end else begin
                me = bq.pop_front();
                if (int'(best_sad) != me.sad || int'(best_x) != me.x ||
                    int'(best_y) != me.y || cyc != me.due) begin
                    errors++;
                    $display("FAIL best: got (%0d,%0d,%0d)@%0d expected (%0d,%0d,%0d)@%0d",
                             best_sad, best_x, best_y, cyc,
                             me.sad, me.x, me.y, me.due);
                end
            end
        end
        if (done) begin
            checks++;
            if (rq.size() > 0 || bq.size() > 0) begin
                errors++;
                $display("FAIL drain: got %0d rows and %0d bests pending expected 0",
                         rq.size(), bq.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    int m[4]  = '{40, 20, 20, 10};
    int mx[4] = '{2, 9, 1, 15};
    int c0;
    int lat;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_row = '0; in_sad = '0; sv = '0;
        w_in_valid = 1'b0; w_in_first = 1'b0; w_in_last = 1'b0;
        w_in_row = '0; w_in_sad = '0;
        repeat (3) @(negedge clk);

        dchk("rst_row_valid", int'(row_valid), 0);
        dchk("rst_best_valid", int'(best_valid), 0);
        dchk("rst_row_sad", int'(row_sad), 4095);
        dchk("rst_best_sad", int'(best_sad), 4095);
        dchk("rst_row_x", int'(row_x), 0);
        dchk("rst_best_xy", int'({best_x, best_y}), 0);
        dchk("rst_w_row_sad", int'(w_row_sad), 65535);
        rst_n = 1'b1;
        idle(2);

        for (int k = 0; k < N; k++) setk(k, 100 - k);
        setk(5, 3);
        beat(1, 1, 7, 3, 5, 3, 5, 7);
        idle(4);

        fill(50);
        for (int r = 0; r < 4; r++)
            beat(r == 0, r == 3, r, 50, 0, 50, 0, 0);
        idle(4);

        for (int r = 0; r < 4; r++) begin
            fill(200);
            setk(mx[r], m[r]);
            beat(r == 0, r == 3, r, m[r], mx[r], 10, 15, 3);
        end
        idle(5);

        fill(90); setk(3, 70);
        beat(1, 0, 0, 70, 3, 0, 0, 0);
        fill(90); setk(4, 30);
        beat(0, 1, 1, 30, 4, 30, 4, 1);
        fill(90); setk(12, 8);
        beat(1, 1, 0, 8, 12, 8, 12, 0);
        idle(4);

        fill(90); setk(1, 20);
        beat(1, 0, 0, 20, 1, 0, 0, 0);
        fill(90); setk(6, 5);
        beat(0, 0, 1, 5, 6, 0, 0, 0);
        fill(90); setk(0, 80);
        beat(0, 0, 2, 80, 0, 0, 0, 0);
        fill(90); setk(2, 60);
        beat(1, 0, 0, 60, 2, 0, 0, 0);
        fill(90); setk(9, 70);
        beat(0, 1, 1, 70, 9, 60, 2, 0);
        idle(6);
        dchk("hold_best_sad", int'(best_sad), 60);
        dchk("hold_best_x", int'(best_x), 2);
        dchk("hold_best_valid", int'(best_valid), 0);
        dchk("hold_row_sad", int'(row_sad), 70);
        drain();

        fill(1);
        @(negedge clk);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        in_row = 4'd3; in_sad = sv;
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dchk("midrst_best_sad", int'(best_sad), 4095);
        dchk("midrst_row_sad", int'(row_sad), 4095);
        dchk("midrst_best_x", int'(best_x), 0);
        dchk("midrst_row_valid", int'(row_valid), 0);
        idle(5);

        fill(4095);
        beat(0, 1, 5, 4095, 0, 4095, 0, 0);
        idle(4);

        for (int k = 0; k < 64; k++) w_in_sad[k*16 +: 16] = 16'hFFFF;
        w_in_sad[63*16 +: 16] = 16'd1;
        @(negedge clk);
        w_in_valid = 1'b1; w_in_first = 1'b1; w_in_last = 1'b1;
        w_in_row = 4'd2;
        c0 = cyc;
        @(negedge clk);
        w_in_valid = 1'b0; w_in_first = 1'b0; w_in_last = 1'b0;
        lat = -1;
        for (int t = 0; t < 10; t++) begin
            if (w_row_valid) begin
                lat = cyc - c0;
                break;
            end
            @(negedge clk);
        end
        dchk("wide_latency", lat, 3);
        dchk("wide_row_x", int'(w_row_x), 63);
        dchk("wide_row_sad", int'(w_row_sad), 1);
        dchk("wide_row_y", int'(w_row_y), 2);
        @(negedge clk);
        dchk("wide_best_valid", int'(w_best_valid), 1);
        dchk("wide_best_x", int'(w_best_x), 63);
        dchk("wide_best_sad", int'(w_best_sad), 1);

        drain();
        done = 1'b1;
    end

endmodule
